// File: rtl/op_flag_retire.sv
// Retire-end op-flag decoder: one-hot flags back to a 2-bit op code, a 2-entry
// in-order retire queue with valid/ready on both sides, and saturating per-op retire counters.
module op_flag_retire #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_flags,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_op,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_add,
    output logic [CNT_W-1:0]  cnt_sub,
    output logic [CNT_W-1:0]  cnt_mul,
    output logic [CNT_W-1:0]  cnt_div,
    output logic [CNT_W-1:0]  cnt_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t              occ;

    logic [1:0]        dec_op;
    logic              dec_err;

    logic [1:0]        head_op;
    logic              head_err;
    logic [DATA_W-1:0] head_data;

    logic [1:0]        tail_op;
    logic              tail_err;
    logic [DATA_W-1:0] tail_data;

    logic              accept;
    logic              retire;

    logic [CNT_W-1:0]  cnt_op [4];
    logic [CNT_W-1:0]  cnt_malformed;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        dec_op  = 2'd0;
        dec_err = 1'b1;
        case (in_flags)
            4'b0001: begin dec_op = 2'd0; dec_err = 1'b0; end
            4'b0010: begin dec_op = 2'd1; dec_err = 1'b0; end
            4'b0100: begin dec_op = 2'd2; dec_err = 1'b0; end
            4'b1000: begin dec_op = 2'd3; dec_err = 1'b0; end
            default: ;
        endcase
    end

    // Ready comes only from registered occupancy and rst, never from out_ready.
    assign in_ready  = (occ != FULL) && !rst;
    assign out_valid = (occ != EMPTY);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= EMPTY;
            head_op   <= 2'd0;
            head_err  <= 1'b0;
            head_data <= '0;
        end else begin
            case (occ)
                EMPTY: begin
                    if (accept) begin
                        occ       <= ONE;
                        head_op   <= dec_op;
                        head_err  <= dec_err;
                        head_data <= in_data;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        head_op   <= dec_op;
                        head_err  <= dec_err;
                        head_data <= in_data;
                    end else if (accept) begin
                        occ <= FULL;
                    end else if (retire) begin
                        occ <= EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        occ       <= ONE;
                        head_op   <= tail_op;
                        head_err  <= tail_err;
                        head_data <= tail_data;
                    end
                end
                default: occ <= EMPTY;
            endcase
        end
    end

    // NOTE: the tail slot is storage only; occupancy qualifies it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (occ == ONE && accept && !retire) begin
            tail_op   <= dec_op;
            tail_err  <= dec_err;
            tail_data <= in_data;
        end
    end

    assign out_op   = head_op;
    assign out_err  = head_err;
    assign out_data = head_data;

    // Clear beats a coincident retire; counters saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            for (int i = 0; i < 4; i++) cnt_op[i] <= '0;
            cnt_malformed <= '0;
        end else if (retire) begin
            if (head_err) begin
                if (cnt_malformed != '1) cnt_malformed <= cnt_malformed + CNT_W'(1);
            end else begin
                if (cnt_op[head_op] != '1) cnt_op[head_op] <= cnt_op[head_op] + CNT_W'(1);
            end
        end
    end

    assign cnt_add = cnt_op[0];
    assign cnt_sub = cnt_op[1];
    assign cnt_mul = cnt_op[2];
    assign cnt_div = cnt_op[3];
    assign cnt_err = cnt_malformed;

endmodule

// File: tb/tb_op_flag_retire.sv
// Bench for op_flag_retire: directed scenarios plus random traffic, all checked
// against a queue-based reference model. Narrow counters make saturation reachable.
module tb_op_flag_retire;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_flags;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_op;
    logic              out_err;
    logic [DATA_W-1:0] out_data;
    logic              clr_cnt;
    logic [CNT_W-1:0]  cnt_add, cnt_sub, cnt_mul, cnt_div, cnt_err;

    op_flag_retire #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_flags(in_flags), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_err(out_err),
        .out_data(out_data), .clr_cnt(clr_cnt),
        .cnt_add(cnt_add), .cnt_sub(cnt_sub), .cnt_mul(cnt_mul), .cnt_div(cnt_div),
        .cnt_err(cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned op;
        bit          err;
        logic [31:0] data;
    } beat_t;

    beat_t mq[$];
    int    mcnt[5];   // add, sub, mul, div, err
    bit    mzero;     // head outputs still hold their reset value
    int    n_vec  = 0;
    int    n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t decode(input logic [3:0] f, input logic [31:0] d);
        beat_t b;
        b.data = d;
        b.op   = 0;
        b.err  = ($countones(f) != 1);
        if (!b.err)
            for (int i = 0; i < 4; i++) if (f[i]) b.op = i;
        return b;
    endfunction

    task automatic compare_all();
        check("in_ready", in_ready, (mq.size() < 2) && !rst);
        check("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("out_op", out_op, mq[0].op);
            check("out_err", out_err, mq[0].err);
            check("out_data", out_data, mq[0].data);
        end else if (mzero) begin
            check("rst_op", out_op, 0);
            check("rst_err", out_err, 0);
            check("rst_data", out_data, 0);
        end
        check("cnt_add", cnt_add, mcnt[0]);
        check("cnt_sub", cnt_sub, mcnt[1]);
        check("cnt_mul", cnt_mul, mcnt[2]);
        check("cnt_div", cnt_div, mcnt[3]);
        check("cnt_err", cnt_err, mcnt[4]);
    endtask

    // One clock: drive inputs, check current outputs, advance DUT and model together.
    task automatic step(input bit v, input logic [3:0] f, input logic [31:0] d,
                        input bit ordy, input bit clr, input bit r, output bit acc);
        bit    ret;
        beat_t h;
        in_valid  = v;
        in_flags  = f;
        in_data   = d;
        out_ready = ordy;
        clr_cnt   = clr;
        rst       = r;
        #1;
        compare_all();
        acc = v && (mq.size() < 2) && !r;
        ret = (mq.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            for (int i = 0; i < 5; i++) mcnt[i] = 0;
            mzero = 1'b1;
        end else begin
            if (ret) begin
                h = mq.pop_front();
                if (!clr) begin
                    if (h.err) begin
                        if (mcnt[4] < CMAX) mcnt[4]++;
                    end else if (mcnt[h.op] < CMAX) begin
                        mcnt[h.op]++;
                    end
                end
            end
            if (clr) for (int i = 0; i < 5; i++) mcnt[i] = 0;
            if (acc) begin
                mq.push_back(decode(f, d));
                mzero = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 32'h0, ordy, 1'b0, 1'b0, a);
    endtask

    initial begin
        bit acc;
        bit got_it;
        in_valid  = 1'b0;
        in_flags  = 4'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        rst       = 1'b1;
        mzero     = 1'b1;
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        @(posedge clk);
        #1;

        // Reset held with a beat offered: it must be dropped.
        for (int i = 0; i < 2; i++) step(1'b1, 4'b0001, 32'hdead, 1'b1, 1'b0, 1'b1, acc);
        idle(1, 1'b1);

        // Decode sweep with out_ready high.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] f;
            f = 4'(1 << i);
            step(1'b1, f, 32'(8'h11 * (i + 1)), 1'b1, 1'b0, 1'b0, acc);
        end
        idle(2, 1'b1);
        check("sweep_cnt_add", cnt_add, 1);
        check("sweep_cnt_div", cnt_div, 1);

        // Malformed tags.
        step(1'b1, 4'b0000, 32'h55, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 4'b0110, 32'h66, 1'b1, 1'b0, 1'b0, acc);
        idle(2, 1'b1);
        check("malformed_cnt_err", cnt_err, 2);
        check("malformed_cnt_sub", cnt_sub, 1);

        // Backpressure: three beats offered, only two fit.
        step(1'b1, 4'b0010, 32'hA1, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 4'b0100, 32'hA2, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 4'b1000, 32'hA3, 1'b0, 1'b0, 1'b0, acc);
        check("bp_third_refused", acc, 0);
        got_it = 1'b0;
        for (int i = 0; i < 8 && !got_it; i++) begin
            step(1'b1, 4'b1000, 32'hA3, 1'b1, 1'b0, 1'b0, acc);
            got_it = acc;
        end
        check("bp_third_accepted", got_it, 1);
        idle(3, 1'b1);

        // Saturation and clear-beats-retire.
        step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < 17; i++) step(1'b1, 4'b0001, 32'(i), 1'b1, 1'b0, 1'b0, acc);
        idle(2, 1'b1);
        check("sat_cnt_add", cnt_add, CMAX);
        step(1'b1, 4'b0001, 32'h77, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b1, 1'b0, acc);
        idle(1, 1'b1);
        check("clr_cnt_add", cnt_add, 0);

        // Reset with a full queue.
        step(1'b1, 4'b0010, 32'hB1, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 4'b0100, 32'hB2, 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b1, acc);
        check("midrst_valid", out_valid, 0);
        check("midrst_cnt_sub", cnt_sub, 0);
        idle(3, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] f;
            f = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, f, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0, acc);
        end
        idle(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
